// File: rtl/regfile_pkg.sv
// Shared constants and state encoding for the register-file dump reader.
package regfile_pkg;

  localparam int WIDTH      = 32;
  localparam int ADDR_WIDTH = 5;
  localparam int NUM_REGS   = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    HOLD,
    DONE
  } dump_state_t;

endpackage

// File: rtl/regfile_dump_reader_if.sv
// Register-file read port plus debug output stream of the dump reader.
// The master side is the dump engine. The slave side is the register file
// mux together with the debug consumer.
interface regfile_dump_reader_if #(
  parameter int WIDTH      = regfile_pkg::WIDTH,
  parameter int ADDR_WIDTH = regfile_pkg::ADDR_WIDTH
);

  logic                  rf_busy;
  logic                  rf_rd_en;
  logic [ADDR_WIDTH-1:0] rf_rd_addr;
  logic [WIDTH-1:0]      rf_rd_data;

  logic                  out_valid;
  logic                  out_ready;
  logic [WIDTH-1:0]      out_data;
  logic [ADDR_WIDTH-1:0] out_addr;
  logic                  out_last;

  modport master (
    input  rf_busy, rf_rd_data, out_ready,
    output rf_rd_en, rf_rd_addr, out_valid, out_data, out_addr, out_last
  );

  modport slave (
    output rf_busy, rf_rd_data, out_ready,
    input  rf_rd_en, rf_rd_addr, out_valid, out_data, out_addr, out_last
  );

endinterface

// File: rtl/regfile_dump_reader_counter.sv
// Loadable wrapping address counter with an end-of-range compare.
// The end value is latched together with the start value, so the range
// stays fixed even if the caller's inputs change mid-dump.
module dump_addr_counter #(
  parameter int ADDR_WIDTH = regfile_pkg::ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_load,
  input  logic                  i_inc,
  input  logic [ADDR_WIDTH-1:0] i_load_val,
  input  logic [ADDR_WIDTH-1:0] i_end_val,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic                  o_is_end
);

  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH-1:0] r_end;

  // Load the range on start, then step through it. Wrap is natural modular overflow.
  // NOTE: sequential state uses non-blocking assignments so that every flop
  // samples pre-edge values, regardless of the order of the statements.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_addr <= '0;
      r_end  <= '0;
    end else if (i_load) begin
      r_addr <= i_load_val;
      r_end  <= i_end_val;
    end else if (i_inc) begin
      r_addr <= r_addr + 1'b1;
    end
  end

  assign o_addr   = r_addr;
  assign o_is_end = (r_addr == r_end);

endmodule

// File: rtl/regfile_dump_reader.sv
// Debug read-out engine. It walks an inclusive, possibly wrapping address
// range over the register-file read port, yielding whenever the CPU owns
// the port. It streams each word with its address over valid/ready, then
// pulses done.
module regfile_dump_reader #(
  parameter int WIDTH      = regfile_pkg::WIDTH,
  parameter int ADDR_WIDTH = regfile_pkg::ADDR_WIDTH,
  parameter int NUM_REGS   = regfile_pkg::NUM_REGS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] first_addr,
  input  logic [ADDR_WIDTH-1:0] last_addr,
  regfile_dump_reader_if.master bus,
  output logic                  busy,
  output logic                  done
);

  import regfile_pkg::*;

  dump_state_t           r_state;
  dump_state_t           w_next;
  logic                  w_load;
  logic                  w_inc;
  logic                  w_capture;
  logic [ADDR_WIDTH-1:0] w_cur_addr;
  logic                  w_is_end;

  logic [WIDTH-1:0]      r_out_data;
  logic [ADDR_WIDTH-1:0] r_out_addr;
  logic                  r_out_last;

  dump_addr_counter #(.ADDR_WIDTH(ADDR_WIDTH)) u_addr_counter (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_load),
    .i_inc      (w_inc),
    .i_load_val (first_addr),
    .i_end_val  (last_addr),
    .o_addr     (w_cur_addr),
    .o_is_end   (w_is_end)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic, read strobe, handshake and done pulse.
  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    w_next         = r_state;
    w_load         = 1'b0;
    w_inc          = 1'b0;
    w_capture      = 1'b0;
    bus.rf_rd_en   = 1'b0;
    bus.rf_rd_addr = '0;
    bus.out_valid  = 1'b0;
    done           = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_load = 1'b1;
          w_next = READ;
        end
      end
      READ: begin
        bus.rf_rd_addr = w_cur_addr;
        if (!bus.rf_busy) begin
          bus.rf_rd_en = 1'b1;
          w_capture    = 1'b1;
          w_next       = HOLD;
        end
      end
      HOLD: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) begin
          if (r_out_last) begin
            w_next = DONE;
          end else begin
            w_inc  = 1'b1;
            w_next = READ;
          end
        end
      end
      DONE: begin
        done   = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Output word register. It loads only on the READ->HOLD edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_out_data <= '0;
      r_out_addr <= '0;
      r_out_last <= 1'b0;
    end else if (w_capture) begin
      r_out_data <= bus.rf_rd_data;
      r_out_addr <= w_cur_addr;
      r_out_last <= w_is_end;
    end
  end

  assign bus.out_data = r_out_data;
  assign bus.out_addr = r_out_addr;
  assign bus.out_last = r_out_last;
  assign busy         = (r_state != IDLE);

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Self-checking bench for regfile_dump_reader. The bench owns the register
// file contents. For each dump it predicts the word sequence arithmetically:
// the number of words is ((last-first) mod 32)+1, the k-th address is
// (first+k) mod 32, and the k-th data is mem at that address. It applies
// random CPU contention and consumer backpressure on the side.
module tb_regfile_dump_reader;

  localparam int N = 32;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [4:0] first_addr = '0;
  logic [4:0] last_addr = '0;
  logic       busy;
  logic       done;

  logic [31:0] mem [N];

  regfile_dump_reader_if bus_if ();

  assign bus_if.rf_rd_data = mem[bus_if.rf_rd_addr];

  regfile_dump_reader dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .first_addr (first_addr),
    .last_addr  (last_addr),
    .bus        (bus_if),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  int done_count = 0;

  always @(negedge clk) if (done === 1'b1) done_count++;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One full dump from start pulse to return to IDLE, checked word by word.
  task automatic do_dump(input logic [4:0] f, input logic [4:0] l, input int busy_pct,
                         input int stall_pct, input bit hammer, input bit check_cycles);
    int          n, k, cycles, exp_a, done0;
    logic [31:0] sd;
    logic [4:0]  sa;
    bit          stalled;
    n     = ((int'(l) - int'(f) + N) % N) + 1;
    done0 = done_count;
    @(posedge clk); #1;
    start = 1'b1; first_addr = f; last_addr = l;
    bus_if.rf_busy = 1'b0; bus_if.out_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    k = 0; cycles = 0; stalled = 0; sd = '0; sa = '0;
    while (k < n && cycles < 2000) begin
      cycles++;
      bus_if.rf_busy   = ($urandom_range(99) < busy_pct);
      bus_if.out_ready = !($urandom_range(99) < stall_pct);
      if (hammer) begin
        start      = 1'($urandom_range(1));
        first_addr = 5'($urandom);
        last_addr  = 5'($urandom);
      end
      @(negedge clk);
      exp_a = (int'(f) + k) % N;
      check("busy_high", busy, 1);
      if (bus_if.rf_busy) check("rd_en_while_cpu", bus_if.rf_rd_en, 0);
      if (bus_if.rf_rd_en) check("rd_addr", bus_if.rf_rd_addr, exp_a);
      if (bus_if.out_valid) begin
        check("hold_rd_en", bus_if.rf_rd_en, 0);
        check("hold_rd_addr", bus_if.rf_rd_addr, 0);
      end
      if (stalled) begin
        check("stall_valid", bus_if.out_valid, 1);
        check("stall_data", bus_if.out_data, sd);
        check("stall_addr", bus_if.out_addr, sa);
      end
      stalled = 0;
      if (bus_if.out_valid === 1'b1) begin
        if (bus_if.out_ready) begin
          check("word_addr", bus_if.out_addr, exp_a);
          check("word_data", bus_if.out_data, mem[exp_a]);
          check("word_last", bus_if.out_last, (k == n - 1) ? 1 : 0);
          k++;
        end else begin
          stalled = 1;
          sd = bus_if.out_data;
          sa = bus_if.out_addr;
        end
      end
      @(posedge clk); #1;
    end
    // This start arrives in the DONE cycle and must be ignored.
    start = hammer;
    bus_if.rf_busy = 1'b0; bus_if.out_ready = 1'b0;
    check("words_complete", k, n);
    if (check_cycles) check("cycle_count", cycles, 2 * n);
    @(negedge clk);
    check("done_pulse", done, 1);
    check("done_valid", bus_if.out_valid, 0);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("done_cleared", done, 0);
    check("idle_busy", busy, 0);
    check("idle_rd_en", bus_if.rf_rd_en, 0);
    check("idle_rd_addr", bus_if.rf_rd_addr, 0);
    check("done_once", done_count - done0, 1);
  endtask

  initial begin
    int  done0;
    bit  found;
    bus_if.rf_busy = 1'b0;
    bus_if.out_ready = 1'b0;
    for (int i = 0; i < N; i++) mem[i] = 32'h1000_0000 + i;

    #1 reset = 1'b0;
    #2;
    check("rst_valid", bus_if.out_valid, 0);
    check("rst_data", bus_if.out_data, 0);
    check("rst_addr", bus_if.out_addr, 0);
    check("rst_last", bus_if.out_last, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rd_en", bus_if.rf_rd_en, 0);
    check("rst_rd_addr", bus_if.rf_rd_addr, 0);
    @(negedge clk) reset = 1'b1;

    // Full dump with no contention: 64 cycles from READ to the last accept.
    do_dump(5'd0, 5'd31, 0, 0, 1'b0, 1'b1);
    // Wrapping range under contention and backpressure.
    do_dump(5'd30, 5'd1, 30, 30, 1'b0, 1'b0);
    // Heavy CPU contention on a short range.
    do_dump(5'd3, 5'd7, 70, 0, 1'b0, 1'b0);
    // Heavy backpressure.
    do_dump(5'd0, 5'd4, 0, 70, 1'b0, 1'b0);
    // Single word while start is hammered during the dump.
    do_dump(5'd7, 5'd7, 20, 20, 1'b1, 1'b0);

    // Random contents and random ranges.
    for (int i = 0; i < N; i++) mem[i] = $urandom;
    for (int r = 0; r < 4; r++)
      do_dump(5'($urandom), 5'($urandom), 25, 25, 1'($urandom_range(1)), 1'b0);

    // Reset while the word at address 10 is held.
    done0 = done_count;
    found = 0;
    @(posedge clk); #1;
    start = 1'b1; first_addr = 5'd8; last_addr = 5'd15;
    bus_if.rf_busy = 1'b0; bus_if.out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (bus_if.out_valid === 1'b1 && bus_if.out_addr === 5'd10) begin
        found = 1;
        break;
      end
      @(posedge clk); #1;
    end
    check("reached_addr10", found, 1);
    reset = 1'b0;
    #1;
    check("arst_valid", bus_if.out_valid, 0);
    check("arst_busy", busy, 0);
    check("arst_rd_en", bus_if.rf_rd_en, 0);
    check("arst_done", done, 0);
    check("arst_data", bus_if.out_data, 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    bus_if.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("arst_no_done", done_count - done0, 0);
    check("arst_idle", busy, 0);

    // Fresh dump after reset.
    do_dump(5'd9, 5'd12, 20, 20, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/regfile_dump_reader.md
# regfile_dump_reader

Debug read-out engine for the 32 x 32-bit register file. On a start pulse it walks an inclusive address range over the register file's read port, yielding to the CPU whenever the CPU owns that port. It streams each word with its address to a debug consumer over a valid/ready handshake, then pulses done. It sits beside the register file, on the opposite side of the port from the per-register write enables.

## Interface
Parameters:
- WIDTH, 32, data width of one register
- ADDR_WIDTH, 5, register address width
- NUM_REGS, 32, number of registers (2**ADDR_WIDTH)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low; 0 clears all state immediately
- start  in  1  begin a dump; sampled only in IDLE
- first_addr  in  ADDR_WIDTH  first register of range; captured on accepted start
- last_addr  in  ADDR_WIDTH  last register of range, inclusive; captured on accepted start
- rf_busy  in  1  CPU owns the read port this cycle; engine must not read
- rf_rd_en  out  1  engine read strobe to port mux
- rf_rd_addr  out  ADDR_WIDTH  engine read address
- rf_rd_data  in  WIDTH  combinational read data for rf_rd_addr, valid same cycle
- out_valid  out  1  out_data/out_addr/out_last valid
- out_ready  in  1  consumer accepts the word when out_valid && out_ready
- out_data  out  WIDTH  captured register contents
- out_addr  out  ADDR_WIDTH  address of out_data
- out_last  out  1  current word is last_addr
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse after the last word is accepted

## Operation
- States:
  - IDLE: start=1 captures first_addr into cur_addr and last_addr into end_addr -> READ.
  - READ: rf_rd_en = !rf_busy, rf_rd_addr = cur_addr. If !rf_busy, rf_rd_data is captured into out_data, cur_addr into out_addr, and (cur_addr==end_addr) into out_last; next state HOLD. If rf_busy, stay in READ with no strobe.
  - HOLD: out_valid=1 with outputs stable. On out_ready: if out_last -> DONE; otherwise cur_addr <= cur_addr+1 mod NUM_REGS -> READ. No out_ready: stay in HOLD.
  - DONE: done=1 for exactly one cycle -> IDLE.
- Address arithmetic is ADDR_WIDTH-bit and wraps 31 -> 0. If first_addr > last_addr, the dump wraps; word count = ((last-first) mod 32) + 1. first==last yields one word.
- start is ignored while busy. start in the same cycle as the DONE state is ignored; start in the following IDLE cycle is accepted.
- rf_rd_en is never high when rf_busy=1 or outside READ. rf_rd_addr=0 when not in READ.
- Register 0 is read like any other register; no special-casing.
- Reset (reset=0) at any time forces IDLE immediately. The dump is abandoned and no done pulse is issued.

## Timing
- Reset values: out_valid=0, out_data=0, out_addr=0, out_last=0, busy=0, done=0, rf_rd_en=0, rf_rd_addr=0.
- start sampled at edge E -> READ (busy=1, rf_rd_en=1 if !rf_busy) in cycle after E -> out_valid=1 one cycle later.
- Best-case throughput: one word per 2 cycles (READ, HOLD), with out_ready held high.
- Each rf_busy cycle in READ adds one cycle. rf_busy has no effect in HOLD.
- Word accepted at edge A with out_last=1 -> done=1 in the cycle after A -> busy=0 one cycle later.
- out_* change only on the READ->HOLD edge. They hold their values in DONE/IDLE, but out_valid=0 there.

## Structure
- Shared package regfile_pkg holds:
  - WIDTH / ADDR_WIDTH / NUM_REGS constants.
  - dump_state_t enum {IDLE, READ, HOLD, DONE}.
- One sub-module, dump_addr_counter: loadable ADDR_WIDTH-bit wrapping counter with load/inc enables and an is_end compare against a loaded end value.
- FSM, output register and handshake stay in the top.

## Test plan
- Full dump: registers preloaded with value 0x1000_0000+i. start, first=0, last=31, out_ready=1, rf_busy=0 -> 32 words, addr 0..31, data matches, out_last only on addr 31, done once, 64 cycles from READ to last accept.
- Wrap: first=30, last=1 -> words at addr 30, 31, 0, 1 in order; out_last on addr 1.
- Contention: rf_busy=1 for 3 cycles while in READ at addr 5 -> no rf_rd_en in those cycles; addr 5 word delayed 3 cycles; data correct.
- Backpressure: out_ready=0 for 4 cycles in HOLD at addr 2 -> out_valid, out_data, out_addr stable; no new read; advance on out_ready=1.
- Single word plus ignored start: first=last=7 -> one word, out_last=1, done pulse. Extra start pulses while busy cause no restart.
- Reset mid-dump: reset=0 during HOLD at addr 10 -> out_valid, busy, rf_rd_en go to 0 asynchronously; no done. Fresh start afterwards dumps correctly.
